dcache_responder: RTL and testbench

Data-side responder for the MEM stage's memory request interface. It takes the per-cycle load/store request (address, byte select, store data, enables) and answers with a 32-bit read word plus a hit/accept flag. Behind it sit a direct-mapped, write-through, no-write-allocate cache with one-word lines, and a store write buffer draining to a simple valid/ready memory bus. Pipeline control treats `ram_en_i && !is_cache_hit_o` as a MEM-stage pause, and the MEM stage holds its request stable during the pause.

---
 rtl/dcache_responder.sv | 166 ++++++++++++++++
 tb/tb_dcache_responder.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_responder.sv
// MEM-stage data responder: direct-mapped, write-through, no-write-allocate
// cache with one-word lines, plus a store write buffer draining to a valid/ready bus.
module dcache_responder #(
  parameter int INDEX_WIDTH = 6,
  parameter int WB_DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ram_en_i,
  input  logic        mem_read_en_i,
  input  logic        mem_write_en_i,
  input  logic [31:0] mem_addr_i,
  input  logic [3:0]  mem_select_i,
  input  logic [31:0] store_data_i,
  output logic [31:0] ram_data_o,
  output logic        is_cache_hit_o,
  output logic        bus_rd_req_o,
  output logic [31:0] bus_rd_addr_o,
  input  logic        bus_rd_ready_i,
  input  logic        bus_rd_valid_i,
  input  logic [31:0] bus_rd_data_i,
  output logic        bus_wr_valid_o,
  output logic [31:0] bus_wr_addr_o,
  output logic [31:0] bus_wr_data_o,
  output logic [3:0]  bus_wr_strb_o,
  input  logic        bus_wr_ready_i
);

  localparam int LINES = 1 << INDEX_WIDTH;
  localparam int TAG_W = 30 - INDEX_WIDTH;
  localparam int PTR_W = $clog2(WB_DEPTH);
  localparam logic [PTR_W:0] WB_FULL = WB_DEPTH[PTR_W:0];

  typedef enum logic [1:0] {IDLE, DRAIN, RD_REQ, RD_WAIT} state_t;

  typedef struct packed {
    logic [29:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } wb_entry_t;

  state_t state_q, state_d;

  logic [LINES-1:0]       valid_q;
  logic [TAG_W-1:0]       tag_q  [LINES];
  logic [31:0]            data_q [LINES];

  wb_entry_t              wb_q [WB_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]         count_q;

  logic [INDEX_WIDTH-1:0] index;
  logic [TAG_W-1:0]       tag;
  logic                   line_hit, req_load, req_store;
  logic                   wb_empty, wb_full, wb_push, wb_pop;
  logic                   merge, fill;
  logic                   addr_unused;

  assign index       = mem_addr_i[INDEX_WIDTH+1:2];
  assign tag         = mem_addr_i[31:INDEX_WIDTH+2];
  assign addr_unused = &{1'b0, mem_addr_i[1:0]};
  assign line_hit    = valid_q[index] && (tag_q[index] == tag);

  // Both enables high is illegal upstream and is resolved as a load.
  assign req_load  = ram_en_i && mem_read_en_i;
  assign req_store = ram_en_i && mem_write_en_i && !mem_read_en_i;

  assign wb_empty = (count_q == '0);
  assign wb_full  = (count_q == WB_FULL);
  assign wb_pop   = bus_wr_valid_o && bus_wr_ready_i;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave a signal unassigned and infer a latch.
  always_comb begin
    state_d        = state_q;
    is_cache_hit_o = 1'b0;
    ram_data_o     = '0;
    bus_rd_req_o   = 1'b0;
    wb_push        = 1'b0;
    merge          = 1'b0;
    fill           = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_load) begin
          if (line_hit) begin
            is_cache_hit_o = 1'b1;
            ram_data_o     = data_q[index];
          end else begin
            state_d = wb_empty ? RD_REQ : DRAIN;
          end
        end else if (req_store && !wb_full) begin
          is_cache_hit_o = 1'b1;
          wb_push        = 1'b1;
          merge          = line_hit;
        end
      end
      // Memory must see all older stores before the refill read.
      DRAIN: if (wb_empty) state_d = RD_REQ;
      RD_REQ: begin
        bus_rd_req_o = 1'b1;
        if (bus_rd_ready_i) state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (bus_rd_valid_i) begin
          fill    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus_rd_addr_o = bus_rd_req_o ? {mem_addr_i[31:2], 2'b00} : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    valid_q        <= '0;
    else if (fill) valid_q[index] <= 1'b1;
  end

  // NOTE: tag/data storage is deliberately not reset; reads are only used
  // behind a valid bit, which is reset.
  always_ff @(posedge clk) begin
    if (fill) begin
      tag_q[index]  <= tag;
      data_q[index] <= bus_rd_data_i;
    end else if (merge) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_select_i[b]) data_q[index][8*b +: 8] <= store_data_i[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wb_push) wb_q[wr_ptr_q] <= '{addr: mem_addr_i[31:2], data: store_data_i, strb: mem_select_i};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wb_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (wb_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({wb_push, wb_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Head fields are gated so the bus sees zeros, not stale storage, when empty.
  assign bus_wr_valid_o = !wb_empty;
  assign bus_wr_addr_o  = bus_wr_valid_o ? {wb_q[rd_ptr_q].addr, 2'b00} : '0;
  assign bus_wr_data_o  = bus_wr_valid_o ? wb_q[rd_ptr_q].data : '0;
  assign bus_wr_strb_o  = bus_wr_valid_o ? wb_q[rd_ptr_q].strb : '0;

endmodule

// File: tb/tb_dcache_responder.sv
// Directed self-checking bench for dcache_responder: refill timing, store merge,
// drain ordering, buffer-full backpressure, eviction and reset mid-refill.
module tb_dcache_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ram_en_i, mem_read_en_i, mem_write_en_i;
  logic [31:0] mem_addr_i, store_data_i;
  logic [3:0]  mem_select_i;
  logic [31:0] ram_data_o;
  logic        is_cache_hit_o;
  logic        bus_rd_req_o;
  logic [31:0] bus_rd_addr_o;
  logic        bus_rd_ready_i, bus_rd_valid_i;
  logic [31:0] bus_rd_data_i;
  logic        bus_wr_valid_o;
  logic [31:0] bus_wr_addr_o, bus_wr_data_o;
  logic [3:0]  bus_wr_strb_o;
  logic        bus_wr_ready_i;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dcache_responder dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ram_en_i       (ram_en_i),
    .mem_read_en_i  (mem_read_en_i),
    .mem_write_en_i (mem_write_en_i),
    .mem_addr_i     (mem_addr_i),
    .mem_select_i   (mem_select_i),
    .store_data_i   (store_data_i),
    .ram_data_o     (ram_data_o),
    .is_cache_hit_o (is_cache_hit_o),
    .bus_rd_req_o   (bus_rd_req_o),
    .bus_rd_addr_o  (bus_rd_addr_o),
    .bus_rd_ready_i (bus_rd_ready_i),
    .bus_rd_valid_i (bus_rd_valid_i),
    .bus_rd_data_i  (bus_rd_data_i),
    .bus_wr_valid_o (bus_wr_valid_o),
    .bus_wr_addr_o  (bus_wr_addr_o),
    .bus_wr_data_o  (bus_wr_data_o),
    .bus_wr_strb_o  (bus_wr_strb_o),
    .bus_wr_ready_i (bus_wr_ready_i)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_none();
    ram_en_i       = 1'b0;
    mem_read_en_i  = 1'b0;
    mem_write_en_i = 1'b0;
    mem_addr_i     = '0;
    mem_select_i   = '0;
    store_data_i   = '0;
  endtask

  task automatic drive_load(input logic [31:0] a);
    drive_none();
    ram_en_i      = 1'b1;
    mem_read_en_i = 1'b1;
    mem_addr_i    = a;
  endtask

  task automatic drive_store(input logic [31:0] a, input logic [3:0] sel, input logic [31:0] d);
    drive_none();
    ram_en_i       = 1'b1;
    mem_write_en_i = 1'b1;
    mem_addr_i     = a;
    mem_select_i   = sel;
    store_data_i   = d;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_hit"},     is_cache_hit_o, 0);
    check({tag, "_rdata"},   ram_data_o, 0);
    check({tag, "_rd_req"},  bus_rd_req_o, 0);
    check({tag, "_rd_addr"}, bus_rd_addr_o, 0);
    check({tag, "_wr_vld"},  bus_wr_valid_o, 0);
    check({tag, "_wr_addr"}, bus_wr_addr_o, 0);
    check({tag, "_wr_data"}, bus_wr_data_o, 0);
    check({tag, "_wr_strb"}, bus_wr_strb_o, 0);
  endtask

  // Empty-buffer refill: miss, request handshake, data, then hit.
  task automatic refill(input string tag, input logic [31:0] a, input logic [31:0] d);
    drive_load(a);
    bus_rd_ready_i = 1'b1;
    #1;
    check({tag, "_miss0"}, is_cache_hit_o, 0);
    tick();
    #1;
    check({tag, "_miss1"}, is_cache_hit_o, 0);
    check({tag, "_req"},   bus_rd_req_o, 1);
    check({tag, "_raddr"}, bus_rd_addr_o, a);
    tick();
    bus_rd_valid_i = 1'b1;
    bus_rd_data_i  = d;
    #1;
    check({tag, "_miss2"}, is_cache_hit_o, 0);
    tick();
    bus_rd_valid_i = 1'b0;
    bus_rd_data_i  = '0;
    #1;
    check({tag, "_hit"},   is_cache_hit_o, 1);
    check({tag, "_data"},  ram_data_o, d);
    tick();
  endtask

  initial begin
    rst_n          = 1'b0;
    bus_rd_ready_i = 1'b0;
    bus_rd_valid_i = 1'b0;
    bus_rd_data_i  = '0;
    bus_wr_ready_i = 1'b0;
    drive_none();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    tick();
    rst_n = 1'b1;

    // Cold load miss: 3 paused cycles, then hit; no-request and re-hit.
    refill("cold", 32'h0000_1000, 32'hDEAD_BEEF);
    drive_none();
    mem_read_en_i = 1'b1;
    #1;
    check("no_req_hit",   is_cache_hit_o, 0);
    check("no_req_rdata", ram_data_o, 0);
    tick();
    drive_load(32'h0000_1000);
    #1;
    check("rehit_hit",  is_cache_hit_o, 1);
    check("rehit_data", ram_data_o, 32'hDEAD_BEEF);
    tick();

    // Store merge on hit, then write buffer presents the store.
    drive_store(32'h0000_1000, 4'b0010, 32'h5555_5555);
    #1;
    check("st_hit_accept", is_cache_hit_o, 1);
    check("st_hit_rdata",  ram_data_o, 0);
    check("st_hit_wr_vld", bus_wr_valid_o, 0);
    tick();
    drive_load(32'h0000_1000);
    #1;
    check("merge_hit",     is_cache_hit_o, 1);
    check("merge_data",    ram_data_o, 32'hDEAD_55EF);
    check("merge_wr_vld",  bus_wr_valid_o, 1);
    check("merge_wr_addr", bus_wr_addr_o, 32'h0000_1000);
    check("merge_wr_strb", bus_wr_strb_o, 4'b0010);
    check("merge_wr_data", bus_wr_data_o, 32'h5555_5555);
    bus_wr_ready_i = 1'b1;
    tick();
    bus_wr_ready_i = 1'b0;
    drive_none();
    #1;
    check("merge_popped", bus_wr_valid_o, 0);
    tick();

    // Store to uncached line, then a load that must drain first.
    drive_store(32'h0000_2000, 4'hF, 32'h1234_5678);
    #1;
    check("unc_accept", is_cache_hit_o, 1);
    tick();
    drive_load(32'h0000_2000);
    #1;
    check("unc_miss", is_cache_hit_o, 0);
    tick();
    #1;
    check("drain_hit",     is_cache_hit_o, 0);
    check("drain_no_req",  bus_rd_req_o, 0);
    check("drain_wr_vld",  bus_wr_valid_o, 1);
    check("drain_wr_addr", bus_wr_addr_o, 32'h0000_2000);
    tick();
    bus_wr_ready_i = 1'b1;
    #1;
    check("drain_pop_no_req", bus_rd_req_o, 0);
    tick();
    bus_wr_ready_i = 1'b0;
    #1;
    check("drain_empty_vld",   bus_wr_valid_o, 0);
    check("drain_empty_noreq", bus_rd_req_o, 0);
    tick();
    bus_rd_ready_i = 1'b0;
    #1;
    check("rdreq_hold",      bus_rd_req_o, 1);
    check("rdreq_hold_addr", bus_rd_addr_o, 32'h0000_2000);
    tick();
    bus_rd_ready_i = 1'b1;
    #1;
    check("rdreq_stable",      bus_rd_req_o, 1);
    check("rdreq_stable_addr", bus_rd_addr_o, 32'h0000_2000);
    tick();
    bus_rd_valid_i = 1'b1;
    bus_rd_data_i  = 32'h1234_5678;
    #1;
    check("unc_wait_hit", is_cache_hit_o, 0);
    tick();
    bus_rd_valid_i = 1'b0;
    bus_rd_data_i  = '0;
    #1;
    check("unc_fill_hit",  is_cache_hit_o, 1);
    check("unc_fill_data", ram_data_o, 32'h1234_5678);
    tick();

    // Buffer full: four accepts, fifth stalls through the pop cycle.
    for (int i = 0; i < 4; i++) begin
      drive_store(32'h40 + 32'(4 * i), 4'hF, 32'hA0 + 32'(i));
      #1;
      check($sformatf("fill_accept%0d", i), is_cache_hit_o, 1);
      tick();
    end
    drive_store(32'h50, 4'hF, 32'hA4);
    #1;
    check("full_reject0", is_cache_hit_o, 0);
    tick();
    #1;
    check("full_reject1", is_cache_hit_o, 0);
    check("full_head",    bus_wr_addr_o, 32'h40);
    bus_wr_ready_i = 1'b1;
    #1;
    check("full_pop_reject", is_cache_hit_o, 0);
    tick();
    bus_wr_ready_i = 1'b0;
    #1;
    check("full_accept",    is_cache_hit_o, 1);
    check("full_head2",     bus_wr_addr_o, 32'h44);
    check("full_head2_dat", bus_wr_data_o, 32'hA1);
    tick();
    drive_none();
    bus_wr_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("fifo_vld%0d", i),  bus_wr_valid_o, 1);
      check($sformatf("fifo_addr%0d", i), bus_wr_addr_o, 32'h44 + 32'(4 * i));
      tick();
    end
    #1;
    check("fifo_empty", bus_wr_valid_o, 0);
    bus_wr_ready_i = 1'b0;
    tick();

    // Conflict eviction on index 0.
    refill("evict_a",  32'h0000_0100, 32'hA1A1_A1A1);
    refill("evict_b",  32'h0001_0100, 32'hB2B2_B2B2);
    refill("evict_a2", 32'h0000_0100, 32'hC3C3_C3C3);

    // Reset during RD_WAIT.
    drive_load(32'h0000_0400);
    bus_rd_ready_i = 1'b1;
    #1;
    check("mid_miss", is_cache_hit_o, 0);
    tick();
    #1;
    check("mid_req", bus_rd_req_o, 1);
    tick();
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_reset");
    tick();
    rst_n = 1'b1;
    drive_load(32'h0000_0100);
    #1;
    check("post_reset_miss", is_cache_hit_o, 0);
    tick();
    #1;
    check("post_reset_req", bus_rd_req_o, 1);
    drive_none();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
